// File: rtl/superkekb_pkg.sv
// Shared constants and types for the SuperKEKB trigger scheduler.
package superkekb_pkg;
    localparam int BUCKETS       = 1280;
    localparam int BUCKET_WIDTH  = 11;
    localparam int TURN_WIDTH    = 8;
    localparam int TIMEOUT_WIDTH = 12;

    localparam logic [BUCKET_WIDTH-1:0]  LAST_BUCKET  = BUCKET_WIDTH'(BUCKETS - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(2 * BUCKETS - 1);

    typedef enum logic [1:0] {IDLE, ARMED, FIRE} state_t;

    typedef struct packed {
        logic [BUCKET_WIDTH-1:0] bucket;
        logic [TURN_WIDTH-1:0]   turns;
    } request_t;
endpackage

// File: rtl/superkekb_position_tracker.sv
// Ring-position tracker: revo edge detect, bucket counter and lock state.
// SUPERKEKB_SCHEDULER_SYNC_CHECK_EN adds the misplaced-edge flag and lock-loss timeout.
module superkekb_position_tracker
    import superkekb_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    revo,
    output logic                    revo_edge,
    output logic                    locked,
    output logic [BUCKET_WIDTH-1:0] position,
    output logic                    sync_error
);
    logic revo_d;
    logic lock_lost;

    assign revo_edge = revo && !revo_d;

`ifdef SUPERKEKB_SCHEDULER_SYNC_CHECK_EN
    logic [TIMEOUT_WIDTH-1:0] idle_count;

    assign lock_lost = locked && !revo_edge && (idle_count == TIMEOUT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_count <= '0;
            sync_error <= 1'b0;
        end else begin
            if (revo_edge || !locked)
                idle_count <= '0;
            else
                idle_count <= idle_count + TIMEOUT_WIDTH'(1);
            // A properly aligned edge always lands on bucket 0.
            if (revo_edge && locked && position != '0)
                sync_error <= 1'b1;
        end
    end
`else
    assign lock_lost  = 1'b0;
    assign sync_error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            revo_d   <= 1'b0;
            locked   <= 1'b0;
            position <= '0;
        end else begin
            revo_d <= revo;
            if (revo_edge) begin
                locked   <= 1'b1;
                position <= BUCKET_WIDTH'(1);
            end else if (lock_lost) begin
                locked   <= 1'b0;
                position <= '0;
            end else if (!locked || position == LAST_BUCKET) begin
                position <= '0;
            end else begin
                position <= position + BUCKET_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/superkekb_trigger_scheduler.sv
// Two-requester bucket-synchronous trigger scheduler with round-robin grant.
// SUPERKEKB_SCHEDULER_SYNC_CHECK_EN enables sync checking in the position tracker.
module superkekb_trigger_scheduler
    import superkekb_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      revo,
    input  logic [1:0]                req_valid,
    input  logic [2*BUCKET_WIDTH-1:0] req_bucket,
    input  logic [2*TURN_WIDTH-1:0]   req_turns,
    output logic [1:0]                req_ready,
    output logic                      locked,
    output logic [BUCKET_WIDTH-1:0]   position,
    output logic                      trigger,
    output logic                      trigger_id,
    output logic                      done,
    output logic                      error,
    output logic                      sync_error
);
    state_t                state, state_next;
    request_t              req;
    logic                  id, err_pending, last_served, grant;
    logic                  revo_edge;
    logic [1:0]            accept;
    logic                  accept_id, grant_next, out_of_range, match;
    logic [TURN_WIDTH-1:0] turns_dec;

    superkekb_position_tracker tracker (
        .clock      (clock),
        .reset      (reset),
        .revo       (revo),
        .revo_edge  (revo_edge),
        .locked     (locked),
        .position   (position),
        .sync_error (sync_error)
    );

    // Grant is a register so req_ready never depends on req_valid.
    assign req_ready    = (locked && state == IDLE) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign accept       = req_valid & req_ready;
    assign accept_id    = accept[1];
    assign grant_next   = (req_valid == 2'b01) ? 1'b0 :
                          (req_valid == 2'b10) ? 1'b1 : !last_served;
    assign turns_dec    = (revo_edge && req.turns != '0) ? req.turns - TURN_WIDTH'(1) : req.turns;
    assign out_of_range = req.bucket > LAST_BUCKET;
    assign match        = (turns_dec == '0) && (position == req.bucket);

    assign done       = (state == FIRE);
    assign trigger    = done && !err_pending;
    assign error      = done && err_pending;
    assign trigger_id = id;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept != 2'b00) state_next = ARMED;
            ARMED:   if (out_of_range || !locked || match) state_next = FIRE;
            FIRE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            req         <= '0;
            id          <= 1'b0;
            err_pending <= 1'b0;
            last_served <= 1'b1;
            grant       <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept != 2'b00) begin
                        req.bucket <= accept_id ? req_bucket[2*BUCKET_WIDTH-1:BUCKET_WIDTH]
                                                : req_bucket[BUCKET_WIDTH-1:0];
                        req.turns  <= accept_id ? req_turns[2*TURN_WIDTH-1:TURN_WIDTH]
                                                : req_turns[TURN_WIDTH-1:0];
                        id         <= accept_id;
                    end else begin
                        grant <= grant_next;
                    end
                end
                ARMED: begin
                    req.turns   <= turns_dec;
                    err_pending <= out_of_range || !locked;
                end
                FIRE: begin
                    last_served <= id;
                    grant       <= !id;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_superkekb_trigger_scheduler.sv
// Scoreboard bench: stimulus pushes expected completions, a monitor checks each done pulse.
module tb_superkekb_trigger_scheduler;
    import superkekb_pkg::*;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      revo = 1'b0;
    logic [1:0]                req_valid;
    logic [2*BUCKET_WIDTH-1:0] req_bucket;
    logic [2*TURN_WIDTH-1:0]   req_turns;
    logic [1:0]                req_ready;
    logic                      locked;
    logic [BUCKET_WIDTH-1:0]   position;
    logic                      trigger, trigger_id, done, error, sync_error;

    superkekb_trigger_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .revo       (revo),
        .req_valid  (req_valid),
        .req_bucket (req_bucket),
        .req_turns  (req_turns),
        .req_ready  (req_ready),
        .locked     (locked),
        .position   (position),
        .trigger    (trigger),
        .trigger_id (trigger_id),
        .done       (done),
        .error      (error),
        .sync_error (sync_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int id;
        int trig;
        int err;
        int pos;
        int rev;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rev_cnt  = 0;
    int   phase    = 0;
    bit   revo_run = 1'b0;
    bit   inject   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input int trig, input int err, input int pos, input int rev);
        exp_t e;
        e.id = id; e.trig = trig; e.err = err; e.pos = pos; e.rev = rev;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int n, input int bucket, input int turns);
        req_bucket[n*BUCKET_WIDTH +: BUCKET_WIDTH] = BUCKET_WIDTH'(bucket);
        req_turns[n*TURN_WIDTH +: TURN_WIDTH]      = TURN_WIDTH'(turns);
    endtask

    task automatic wait_pos(input int p, input int limit);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (position != p && k < limit);
        chk($sformatf("reach_pos_%0d", p), position, p);
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clock);
            k++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic chk_reset_values();
        chk("rst_ready", req_ready, 0);
        chk("rst_locked", locked, 0);
        chk("rst_position", position, 0);
        chk("rst_trigger", trigger, 0);
        chk("rst_trigger_id", trigger_id, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_sync_error", sync_error, 0);
    endtask

    // Revolution marker source; inject forces one misplaced edge and realigns.
    always @(negedge clock) begin
        if (inject) begin
            revo = 1'b1;
            phase = 1;
            rev_cnt++;
            inject = 1'b0;
        end else if (revo_run) begin
            revo = (phase == 0);
            if (phase == 0) rev_cnt++;
            phase = (phase == BUCKETS - 1) ? 0 : phase + 1;
        end else begin
            revo = 1'b0;
        end
    end

    // Completion monitor.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && trigger && !done) chk("trigger_without_done", done, 1);
        if (!reset && done) begin
            chk("pending_expect", exp_q.size(), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("done_id", trigger_id, e.id);
                chk("done_trigger", trigger, e.trig);
                chk("done_error", error, e.err);
                chk("done_position", position, e.pos);
                chk("done_revolution", rev_cnt, e.rev);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        reset = 1'b1; req_valid = 2'b00; req_bucket = '0; req_turns = '0;
        repeat (3) @(negedge clock);
        chk_reset_values();
        reset = 1'b0;

        // No revo: stays unlocked and refuses requests.
        req_valid = 2'b11;
        repeat (3000) @(negedge clock);
        chk("unlocked_locked", locked, 0);
        chk("unlocked_ready", req_ready, 0);
        req_valid = 2'b00;

        @(posedge clock); revo_run = 1'b1;
        @(negedge clock); chk("lock_pending", locked, 0);
        @(negedge clock); chk("lock_rise", locked, 1); chk("pos_1", position, 1);
        @(negedge clock); chk("pos_2", position, 2);
        repeat (1277) @(negedge clock);
        chk("pos_1279", position, 1279);
        @(negedge clock); chk("pos_wrap", position, 0);
        chk("sync_error_clear", sync_error, 0);

        // Requester 0, bucket 100, turns 0, accepted at position 50.
        wait_pos(50, 1400);
        set_req(0, 100, 0); req_valid = 2'b01;
        chk("t2_ready", req_ready, 1);
        push_exp(0, 1, 0, 101, rev_cnt);
        @(negedge clock); req_valid = 2'b00;
        drain(100);

        // Requester 1, out-of-range bucket: error done at A+2.
        wait_pos(200, 1400);
        set_req(1, 1300, 0); req_valid = 2'b10;
        chk("t4_ready", req_ready, 2);
        push_exp(1, 0, 1, 202, rev_cnt);
        @(negedge clock); req_valid = 2'b00;
        drain(10);

        // Both requesters continuously valid: grants alternate.
        wait_pos(300, 1400);
        set_req(0, 10, 1); set_req(1, 10, 1); req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (req_ready == 2'b00 && w < 3000) begin @(negedge clock); w++; end
            chk($sformatf("alt_grant_%0d", k), req_ready, (k % 2 == 1) ? 2 : 1);
            chk($sformatf("alt_pos_%0d", k), position, (k == 0) ? 300 : 12);
            push_exp(k % 2, 1, 0, 11, rev_cnt + 1);
            @(negedge clock);
        end
        req_valid = 2'b00;
        drain(3000);

`ifdef SUPERKEKB_SCHEDULER_SYNC_CHECK_EN
        wait_pos(699, 1400);
        @(posedge clock); inject = 1'b1;
        @(negedge clock); chk("inject_pos", position, 700);
        @(negedge clock); chk("sync_error_set", sync_error, 1); chk("resync_pos", position, 1);
        set_req(0, 500, 5); req_valid = 2'b01;
        chk("to_ready", req_ready, 1);
        push_exp(0, 0, 1, 0, rev_cnt);
        @(negedge clock); req_valid = 2'b00;
        wait_pos(1, 1400);
        @(posedge clock); revo_run = 1'b0;
        w = 0;
        while (locked && w < 3000) begin @(negedge clock); w++; end
        chk("lock_loss_cycles", w, 2560);
        chk("sync_error_sticky", sync_error, 1);
        drain(5);
        @(posedge clock); revo_run = 1'b1;
        w = 0;
        while (!locked && w < 3000) begin @(negedge clock); w++; end
        chk("relock", locked, 1);
`endif

        // Ordinary request so requester 0 is last served before the reset test.
        wait_pos(400, 1400);
        set_req(0, 600, 0); req_valid = 2'b01;
        w = 0;
        while (!req_ready[0] && w < 10) begin @(negedge clock); w++; end
        chk("t5_ready", req_ready, 1);
        push_exp(0, 1, 0, 601, rev_cnt);
        @(negedge clock); req_valid = 2'b00;
        drain(1400);

        // Arm requester 1, then reset: request is dropped, priority back to 0.
        set_req(1, 1000, 3); req_valid = 2'b10;
        chk("rst_arm_ready", req_ready, 2);
        @(negedge clock); req_valid = 2'b00;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        chk_reset_values();
        reset = 1'b0;
        set_req(0, 5, 0); set_req(1, 5, 0); req_valid = 2'b11;
        w = 0;
        while (req_ready == 2'b00 && w < 3000) begin @(negedge clock); w++; end
        chk("post_rst_grant", req_ready, 1);
        chk("post_rst_pos", position, 1);
        push_exp(0, 1, 0, 6, rev_cnt);
        @(negedge clock); req_valid = 2'b00;
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
